// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encodings,
// flag bundle and the slice-width helper.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } alu_flags_t;

    // Every slice is this wide except the last, which takes the remainder.
    function automatic int slice_width(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SW-bit adder slice with carry in/out and a tap of the carry
// into its MSB, used to form signed overflow in the top slice.
module addsub_slice #(
    parameter int SW = 3
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          c_in,
    output logic [SW-1:0] sum,
    output logic          c_out,
    output logic          c_msb
);

    logic [SW:0] full;

    always_comb begin
        full  = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, c_in};
        sum   = full[SW-1:0];
        c_out = full[SW];
        c_msb = a[SW-1] ^ b[SW-1] ^ full[SW-1];
    end

endmodule

// File: rtl/alu_addsub_pipe.sv
// Pipelined add/subtract unit: carry chain split into STAGES registered slices,
// valid/ready on both sides with a global stall. Define ALU_ADDSUB_SAT_EN for sat_mode.
module alu_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             cin,
`ifdef ALU_ADDSUB_SAT_EN
    input  logic             sat_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int SW = slice_width(WIDTH, STAGES);
    localparam int LW = WIDTH - (STAGES - 1) * SW;
    localparam int NI = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int L  = STAGES - 1;
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
        $error("alu_addsub_pipe: STAGES must be within 1..WIDTH");
    end
    if (LW < 1) begin : g_bad_split
        $error("alu_addsub_pipe: WIDTH/STAGES leaves no bits for the last slice");
    end

    // Per-stage slice inputs (skewed operands, partial result, carry, control)
    logic [WIDTH-1:0] a_s   [STAGES];
    logic [WIDTH-1:0] b_s   [STAGES];
    logic [WIDTH-1:0] acc_s [STAGES];
    logic             c_s   [STAGES];
    logic             v_s   [STAGES];
    logic             sat_s [STAGES];
    logic [WIDTH-1:0] acc_o [STAGES];
    logic             co_o  [STAGES];
    logic             cm_o  [STAGES];

    logic [WIDTH-1:0] a_q [NI], a_d [NI];
    logic [WIDTH-1:0] b_q [NI], b_d [NI];
    logic [WIDTH-1:0] acc_q [NI], acc_d [NI];
    logic             c_q [NI], c_d [NI];
    logic             v_q [NI], v_d [NI];
    logic             sat_q [NI], sat_d [NI];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    alu_flags_t       flags_q, flags_d;

    logic             stall;
    logic             c0;
    logic             sat_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] res_f;
    logic             ovf_f;
    alu_flags_t       flags_f;

`ifdef ALU_ADDSUB_SAT_EN
    assign sat_in = sat_mode;
`else
    assign sat_in = 1'b0;
`endif

    // Subtraction is A + ~B + c0
    always_comb begin
        c0   = 1'b0;
        b_in = operand_b;
        case (alu_op_t'(op))
            OP_ADD: c0 = 1'b0;
            OP_SUB: begin c0 = 1'b1; b_in = ~operand_b; end
            OP_ADC: c0 = cin;
            OP_SBC: begin c0 = cin;  b_in = ~operand_b; end
            default: c0 = 1'b0;
        endcase
    end

    always_comb begin
        a_s[0]   = operand_a;
        b_s[0]   = b_in;
        acc_s[0] = '0;
        c_s[0]   = c0;
        v_s[0]   = in_valid;
        sat_s[0] = sat_in;
        for (int k = 1; k < STAGES; k++) begin
            a_s[k]   = a_q[k-1];
            b_s[k]   = b_q[k-1];
            acc_s[k] = acc_q[k-1];
            c_s[k]   = c_q[k-1];
            v_s[k]   = v_q[k-1];
            sat_s[k] = sat_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        localparam int LO  = k * SW;
        localparam int SWK = (k == STAGES - 1) ? LW : SW;
        logic [SWK-1:0]   sum_w;
        logic             co_w;
        logic             cm_w;
        logic [WIDTH-1:0] merged;

        addsub_slice #(.SW(SWK)) u_slice (
            .a     (a_s[k][LO +: SWK]),
            .b     (b_s[k][LO +: SWK]),
            .c_in  (c_s[k]),
            .sum   (sum_w),
            .c_out (co_w),
            .c_msb (cm_w)
        );

        always_comb begin
            merged            = acc_s[k];
            merged[LO +: SWK] = sum_w;
        end

        assign acc_o[k] = merged;
        assign co_o[k]  = co_w;
        assign cm_o[k]  = cm_w;
    end

    // Final stage: flags from the complete result, optional clamp
    always_comb begin
        ovf_f = co_o[L] ^ cm_o[L];
        res_f = acc_o[L];
        if (sat_s[L] && ovf_f) begin
            res_f = acc_o[L][WIDTH-1] ? SAT_POS : SAT_NEG;
        end
        flags_f.carry    = co_o[L];
        flags_f.overflow = ovf_f;
        flags_f.zero     = (res_f == '0);
        flags_f.negative = res_f[WIDTH-1];
    end

    always_comb begin
        stall       = out_valid_q && !out_ready;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        c_d         = c_q;
        v_d         = v_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (!stall) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                a_d[k]   = a_s[k];
                b_d[k]   = b_s[k];
                acc_d[k] = acc_o[k];
                c_d[k]   = co_o[k];
                v_d[k]   = v_s[k];
                sat_d[k] = sat_s[k];
            end
            out_valid_d = v_s[L];
            if (v_s[L]) begin
                result_d = res_f;
                flags_d  = flags_f;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                acc_q[k] <= '0;
                c_q[k]   <= 1'b0;
                v_q[k]   <= 1'b0;
                sat_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            c_q         <= c_d;
            v_q         <= v_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign in_ready  = !stall;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = flags_q.carry;
    assign overflow  = flags_q.overflow;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;

endmodule

// File: doc/alu_addsub_pipe.md
Name: alu_addsub_pipe

Overview:
Parametrised, pipelined add/subtract unit. It is the successor to the team's fixed 5-bit ripple adder and the arithmetic core of the next-generation ALU. The carry chain is split into STAGES registered slices, and each slice computes WIDTH/STAGES bits per cycle. A valid/ready handshake sits on both sides, and the unit produces carry, signed-overflow, zero and negative flags.

Parameters:
WIDTH, 5, operand/result width in bits (2..64).
STAGES, 2, number of pipeline slices and cycles of latency (1..WIDTH).
- Slice width is SW = ceil(WIDTH/STAGES).
- The last slice takes the remainder bits.
- STAGES > WIDTH is an elaboration error.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand beat offered.
in_ready  out  1  unit accepts the beat this cycle.
op  in  2  operation: 00 ADD, 01 SUB, 10 ADC (a+b+cin), 11 SBC (a-b-!cin).
operand_a  in  WIDTH  operand A.
operand_b  in  WIDTH  operand B.
cin  in  1  carry-in, used by ADC/SBC only.
out_valid  out  1  result beat present.
out_ready  in  1  downstream accepts the result.
result  out  WIDTH  A op B, modulo 2^WIDTH.
carry_out  out  1  carry out of the MSB (for SUB/SBC: 1 = no borrow).
overflow  out  1  two's-complement signed overflow.
zero  out  1  result == 0.
negative  out  1  result[WIDTH-1].

Behaviour:
- Reset: clock and reset ports are clk (single clock) and rst_n, asynchronous active-low. While rst_n is low:
  - all stage valid bits clear, so out_valid = 0;
  - result, carry_out, overflow, zero and negative = 0;
  - in_ready = 1 once released.
- Arithmetic: SUB/SBC are implemented as A + ~B + c0.
  - c0 = 0 for ADD, 1 for SUB, cin for ADC, cin for SBC.
  - SBC computes a - b - !cin.
- Slicing:
  - Stage k adds bits [k*SW +: SW] of the skewed operands plus the registered carry from stage k-1.
  - The upper operand bits are delay-registered so they align with their slice.
  - Lower result bits are carried forward in pipeline registers.
- Flags are formed in the final stage from the complete result.
  - overflow = carry into MSB XOR carry out of MSB.
- Latency: a beat accepted at edge N (in_valid && in_ready) appears with out_valid = 1 after edge N+STAGES-1, i.e. in the cycle following edge N+STAGES-1.
  - STAGES = 1 gives one registered output stage.
- Throughput: one beat per cycle when out_ready = 1.
- Backpressure: global stall.
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - When stalled, every stage register holds and no beat is accepted or lost.
- Bubbles: a stage with no valid beat advances as an empty slot even while later stages are stalled. This is optional; the minimum requirement is a global hold, and it is specified as global hold.
- Output stability: result and flags stay stable while out_valid && !out_ready.
- Wrap-around: the result is modulo 2^WIDTH. carry_out and overflow report the wrap; there is no saturation by default.
- Simultaneous accept and retire: allowed in the same cycle. The pipeline shifts and holds no extra state.
- Mid-operation reset: all in-flight beats are discarded. No output beat appears after rst_n deasserts unless new input is accepted.
- op, cin and operands are sampled only on accept. Values offered without in_valid are ignored.

Optional Feature:
ALU_ADDSUB_SAT_EN.
- Defined: adds input port sat_mode (1 bit, sampled with the beat).
  - When sat_mode = 1 and overflow occurs, result clamps to the signed extreme: 0b0111…1 if the true result is positive, 0b1000…0 if negative.
  - overflow still reports 1.
  - zero and negative reflect the clamped result.
- Undefined: no sat_mode port, and the result always wraps.

Decomposition:
- Shared package alu_pkg:
  - op encodings OP_ADD/OP_SUB/OP_ADC/OP_SBC as a 2-bit typedef alu_op_t;
  - localparam function for slice width;
  - flag struct alu_flags_t {carry, overflow, zero, negative}.
- Sub-module addsub_slice: combinational SW-bit adder with carry in/out and MSB carry-in tap for overflow, instantiated STAGES times via generate.
- Pipeline registers and handshake logic live in alu_addsub_pipe.

Test Plan:
- WIDTH=5, STAGES=2, ADD 5'd13 + 5'd9 -> result 5'd22, carry 0, overflow 1 (13+9 exceeds +15), negative 1, out_valid exactly 2 cycles after accept.
- SUB 5'd7 - 5'd7 -> result 0, zero 1, carry_out 1 (no borrow), overflow 0.
- ADC 5'd31 + 5'd0 with cin=1 -> result 0, carry_out 1, zero 1, overflow 0. SBC 5'd3 - 5'd5 with cin=1 -> 5'd30, carry_out 0, negative 1.
- Stream 8 back-to-back beats with out_ready held low for cycles 3..6 -> in_ready low while stalled, all 8 results emerge in order, none dropped or duplicated, outputs stable during stall.
- Assert rst_n low with 2 beats in flight -> out_valid drops immediately. After release, no stale beats appear and the next accepted beat completes normally.
- With ALU_ADDSUB_SAT_EN, sat_mode=1, ADD 5'd15 + 5'd1 -> result 5'd15, overflow 1. SUB 5'd16 - 5'd1 (-16-1) -> result 5'd16.
